// File: rtl/store_monitor.sv
// Store-interface responder: classifies processor stores against the completion
// protocol, logs them into a first-word-fall-through FIFO and detects idle hangs.
module store_monitor #(
    parameter logic [31:0] DONE_ADR    = 32'd100,
    parameter logic [31:0] DONE_VAL    = 32'd7,
    parameter logic [31:0] SCRATCH_ADR = 32'd96,
    parameter int          LOG_DEPTH   = 8,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    input  logic        log_rd,
    output logic        log_valid,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_overflow
);

    localparam int AW     = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [15:0]         count_q, count_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                timeout_q, timeout_d;
    logic                push;

    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                valid_q, valid_d;
    logic [63:0]         head_q, head_d;
    logic [63:0]         mem_q [LOG_DEPTH];
    logic                fifo_empty, fifo_full, pop_ok, push_ok;

    // Run-state classification and idle watchdog
    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        push      = 1'b0;
        if (state_q == ST_RUN) begin
            if (MemWrite) begin
                push   = 1'b1;
                idle_d = '0;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
                if (DataAdr == DONE_ADR && WriteData == DONE_VAL) begin
                    state_d = ST_PASS;
                end else if (DataAdr != SCRATCH_ADR) begin
                    state_d = ST_FAIL;
                end
            end else if (idle_q == IDLE_MAX) begin
                state_d   = ST_FAIL;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};
            end
        end
        pass_d = (state_d == ST_PASS);
        fail_d = (state_d == ST_FAIL);
        done_d = pass_d | fail_d;
    end

    // Log FIFO; the extra pointer bit separates full from empty
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok     = log_rd && !fifo_empty;
        push_ok    = push && (!fifo_full || pop_ok);
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        overflow_d = overflow_q | (push && !push_ok);
        valid_d    = 1'b0;
        head_d     = '0;
        if (wr_ptr_d != rd_ptr_d) begin
            valid_d = 1'b1;
            // The new head may be the entry being written on this very edge
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                head_d = {DataAdr, WriteData};
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {DataAdr, WriteData};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            idle_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            count_q    <= count_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign timeout      = timeout_q;
    assign store_count  = count_q;
    assign log_valid    = valid_q;
    assign log_adr      = head_q[63:32];
    assign log_data     = head_q[31:0];
    assign log_overflow = overflow_q;

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_store_monitor;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        log_rd = 1'b0;
    logic        done, pass, fail, timeout, log_valid, log_overflow;
    logic [15:0] store_count;
    logic [31:0] log_adr, log_data;

    store_monitor #(
        .DONE_ADR(32'd100), .DONE_VAL(32'd7), .SCRATCH_ADR(32'd96),
        .LOG_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .store_count(store_count), .log_rd(log_rd),
        .log_valid(log_valid), .log_adr(log_adr), .log_data(log_data),
        .log_overflow(log_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 = RUN, 1 = PASS, 2 = FAIL
    int          m_state;
    bit          m_timeout;
    int          m_count;
    bit          m_ovf;
    int          m_edge;
    int          m_last;
    logic [63:0] m_q[$];

    task automatic model_clear();
        m_state = 0; m_timeout = 0; m_count = 0; m_ovf = 0;
        m_edge = 0; m_last = 0; m_q.delete();
    endtask

    task automatic model_step(input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic rd);
        bit pop_ok, do_push;
        pop_ok  = rd && (m_q.size() > 0);
        do_push = 0;
        m_edge++;
        if (m_state == 0) begin
            if (we) begin
                m_last = m_edge;
                if (m_count < 65535) m_count++;
                if (m_q.size() - (pop_ok ? 1 : 0) < DEPTH) do_push = 1;
                else m_ovf = 1;
                if (adr == 32'd100 && dat == 32'd7) m_state = 1;
                else if (adr != 32'd96) m_state = 2;
            end else if (m_edge - m_last == TMO + 1) begin
                m_state = 2;
                m_timeout = 1;
            end
        end
        if (pop_ok) void'(m_q.pop_front());
        if (do_push) m_q.push_back({adr, dat});
    endtask

    task automatic cycle(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic rd);
        MemWrite = we; DataAdr = adr; WriteData = dat; log_rd = rd;
        @(posedge clk);
        model_step(we, adr, dat, rd);
        #1;
        MemWrite = 1'b0; log_rd = 1'b0;
    endtask

    task automatic do_reset();
        MemWrite = 1'b0; log_rd = 1'b0;
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({done, pass, fail, timeout} !== 4'b0) begin errors++;
            $display("FAIL reset_status got %b required 0000", {done, pass, fail, timeout}); end
        checks++; if (store_count !== 16'd0) begin errors++;
            $display("FAIL reset_count got %0d required 0", store_count); end
        checks++; if ({log_valid, log_overflow} !== 2'b00) begin errors++;
            $display("FAIL reset_fifo_flags got %b required 00", {log_valid, log_overflow}); end
        checks++; if ({log_adr, log_data} !== 64'd0) begin errors++;
            $display("FAIL reset_head got %h required 0", {log_adr, log_data}); end
        #1 reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_scratch_done();
        do_reset();
        cycle(1, 32'd96, 32'd3, 0);
        checks++; if (done !== 1'b0 || store_count !== 16'd1) begin errors++;
            $display("FAIL sd_first got done=%b cnt=%0d required done=0 cnt=1", done, store_count); end
        cycle(1, 32'd100, 32'd7, 0);
        checks++; if ({pass, done, fail} !== 3'b110) begin errors++;
            $display("FAIL sd_pass got pdf=%b required 110", {pass, done, fail}); end
        checks++; if (store_count !== 16'd2) begin errors++;
            $display("FAIL sd_count got %0d required 2", store_count); end
        checks++; if (log_valid !== 1'b1 || {log_adr, log_data} !== {32'h60, 32'd3}) begin errors++;
            $display("FAIL sd_head0 got v=%b %h required v=1 00000060_00000003", log_valid, {log_adr, log_data}); end
        cycle(0, 0, 0, 1);
        checks++; if (log_valid !== 1'b1 || {log_adr, log_data} !== {32'h64, 32'd7}) begin errors++;
            $display("FAIL sd_head1 got v=%b %h required v=1 00000064_00000007", log_valid, {log_adr, log_data}); end
        cycle(0, 0, 0, 1);
        checks++; if (log_valid !== 1'b0) begin errors++;
            $display("FAIL sd_empty got %b required 0", log_valid); end
        cycle(0, 0, 0, 1);
        checks++; if (log_valid !== 1'b0 || pass !== 1'b1) begin errors++;
            $display("FAIL sd_pop_empty got v=%b pass=%b required v=0 pass=1", log_valid, pass); end
        $display("test_scratch_done done");
    endtask

    task automatic test_wrong_value();
        do_reset();
        cycle(1, 32'd100, 32'd6, 0);
        checks++; if ({fail, timeout, pass} !== 3'b100) begin errors++;
            $display("FAIL wv_fail got fail,to,pass=%b required 100", {fail, timeout, pass}); end
        cycle(1, 32'd100, 32'd7, 0);
        checks++; if (store_count !== 16'd1 || pass !== 1'b0 || fail !== 1'b1) begin errors++;
            $display("FAIL wv_ignored got cnt=%0d pass=%b fail=%b required 1 0 1", store_count, pass, fail); end
        $display("test_wrong_value done");
    endtask

    task automatic test_illegal();
        do_reset();
        cycle(1, 32'h40, 32'd7, 0);
        checks++; if (fail !== 1'b1 || timeout !== 1'b0) begin errors++;
            $display("FAIL il_fail got fail=%b to=%b required 1 0", fail, timeout); end
        checks++; if (log_valid !== 1'b1 || {log_adr, log_data} !== {32'h40, 32'd7}) begin errors++;
            $display("FAIL il_log got v=%b %h required v=1 00000040_00000007", log_valid, {log_adr, log_data}); end
        $display("test_illegal done");
    endtask

    task automatic test_timeout();
        do_reset();
        for (int e = 1; e <= TMO + 1; e++) begin
            cycle(0, 0, 0, 0);
            checks++; if (fail !== (e == TMO + 1) || timeout !== (e == TMO + 1)) begin errors++;
                $display("FAIL to_idle edge=%0d got fail=%b to=%b required %b", e, fail, timeout, e == TMO + 1); end
        end
        // Store lands on the expiry edge: the store is classified instead
        do_reset();
        repeat (TMO) cycle(0, 0, 0, 0);
        cycle(1, 32'd96, 32'd1, 0);
        checks++; if (fail !== 1'b0 || store_count !== 16'd1) begin errors++;
            $display("FAIL to_store_wins got fail=%b cnt=%0d required 0 1", fail, store_count); end
        repeat (TMO) cycle(0, 0, 0, 0);
        checks++; if (fail !== 1'b0) begin errors++;
            $display("FAIL to_restart_early got %b required 0", fail); end
        cycle(0, 0, 0, 0);
        checks++; if (fail !== 1'b1 || timeout !== 1'b1) begin errors++;
            $display("FAIL to_restart got fail=%b to=%b required 1 1", fail, timeout); end
        $display("test_timeout done");
    endtask

    task automatic test_fifo_stress();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 32'd96, 32'h100 + i, 0);
        checks++; if (store_count !== 16'd6 || log_overflow !== 1'b1) begin errors++;
            $display("FAIL fs_ovf got cnt=%0d ovf=%b required 6 1", store_count, log_overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (log_valid !== 1'b1 || log_data !== 32'h100 + i) begin errors++;
                $display("FAIL fs_drain%0d got v=%b data=%h required v=1 %h", i, log_valid, log_data, 32'h100 + i); end
            cycle(0, 0, 0, 1);
        end
        checks++; if (log_valid !== 1'b0) begin errors++;
            $display("FAIL fs_empty got %b required 0", log_valid); end
        // Fill exactly, then push and pop together while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'd96, 32'h200 + i, 0);
        d = $urandom;
        cycle(1, 32'd96, d, 1);
        checks++; if (log_overflow !== 1'b0 || log_data !== 32'h201) begin errors++;
            $display("FAIL fs_pushpop got ovf=%b head=%h required 0 00000201", log_overflow, log_data); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (log_valid !== 1'b1 || {log_adr, log_data} !== m_q[0]) begin errors++;
                $display("FAIL fs_order%0d got %h required %h", i, {log_adr, log_data}, m_q[0]); end
            cycle(0, 0, 0, 1);
        end
        checks++; if (log_valid !== 1'b0 || m_q.size() != 0) begin errors++;
            $display("FAIL fs_final_empty got %b required 0", log_valid); end
        $display("test_fifo_stress done");
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 32'd96, $urandom, 0);
        #2 reset = 1'b1;
        model_clear();
        #1;
        checks++; if ({done, pass, fail, timeout, log_valid, log_overflow} !== 6'b0 ||
                      store_count !== 16'd0 || {log_adr, log_data} !== 64'd0) begin errors++;
            $display("FAIL mr_async got flags=%b cnt=%0d head=%h required all 0",
                     {done, pass, fail, timeout, log_valid, log_overflow}, store_count, {log_adr, log_data}); end
        @(posedge clk);
        #2 reset = 1'b0;
        cycle(1, 32'd100, 32'd7, 0);
        checks++; if (pass !== 1'b1 || store_count !== 16'd1) begin errors++;
            $display("FAIL mr_after got pass=%b cnt=%0d required 1 1", pass, store_count); end
        $display("test_reset_midrun done");
    endtask

    task automatic test_random();
        int          rate;
        int          sel;
        logic        we, rd;
        logic [31:0] adr, dat;
        do_reset();
        rate = 3;
        for (int i = 0; i < 800; i++) begin
            if (m_state != 0 && $urandom_range(0, 7) == 0) begin
                do_reset();
                rate = $urandom_range(2, 40);
            end
            we  = ($urandom_range(1, rate) == 1);
            rd  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 29);
            dat = $urandom;
            if (sel == 0) begin adr = 32'd100; dat = 32'd7; end
            else if (sel == 1) adr = 32'd100;
            else if (sel == 2) adr = $urandom;
            else adr = 32'd96;
            cycle(we, adr, dat, rd);
            checks++; if ({done, pass, fail, timeout} !==
                          {m_state != 0, m_state == 1, m_state == 2, m_timeout}) begin errors++;
                $display("FAIL rnd_status cyc=%0d got dpft=%b required %b%b%b%b", i,
                         {done, pass, fail, timeout}, m_state != 0, m_state == 1, m_state == 2, m_timeout); end
            checks++; if (store_count !== 16'(m_count) || log_overflow !== m_ovf) begin errors++;
                $display("FAIL rnd_count cyc=%0d got cnt=%0d ovf=%b required %0d %b", i,
                         store_count, log_overflow, m_count, m_ovf); end
            checks++; if (log_valid !== (m_q.size() > 0)) begin errors++;
                $display("FAIL rnd_valid cyc=%0d got %b required %b", i, log_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                checks++; if ({log_adr, log_data} !== m_q[0]) begin errors++;
                    $display("FAIL rnd_head cyc=%0d got %h required %h", i, {log_adr, log_data}, m_q[0]); end
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_scratch_done();
        test_wrong_value();
        test_illegal();
        test_timeout();
        test_fifo_stress();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
